// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: memory option codes and the machine word type.
package mips_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  mem_op_t;

    localparam mem_op_t MEMOP_LW  = 4'b0010;
    localparam mem_op_t MEMOP_LWL = 4'b0011;
    localparam mem_op_t MEMOP_LWR = 4'b0101;
    localparam mem_op_t MEMOP_LB  = 4'b0110;
    localparam mem_op_t MEMOP_LBU = 4'b0111;
    localparam mem_op_t MEMOP_LH  = 4'b1000;
    localparam mem_op_t MEMOP_LHU = 4'b1001;

endpackage

// File: rtl/load_align.sv
// Combinational load-result alignment; merges lwl/lwr with the old rt value, others pass through.
module load_align
    import mips_pkg::*;
(
    input  mem_op_t    mem_op,
    input  logic [1:0] k,
    input  word_t      mem_rdata,
    input  word_t      rt_old,
    output word_t      load_val
);

    always_comb begin
        load_val = mem_rdata;
        case (mem_op)
            // Unaligned-left: memory supplies the upper 4-k bytes.
            MEMOP_LWL: begin
                unique case (k)
                    2'd0: load_val = mem_rdata;
                    2'd1: load_val = {mem_rdata[31:8], rt_old[7:0]};
                    2'd2: load_val = {mem_rdata[31:16], rt_old[15:0]};
                    2'd3: load_val = {mem_rdata[31:24], rt_old[23:0]};
                endcase
            end
            // Unaligned-right: memory supplies the lower k+1 bytes.
            MEMOP_LWR: begin
                unique case (k)
                    2'd0: load_val = {rt_old[31:8], mem_rdata[7:0]};
                    2'd1: load_val = {rt_old[31:16], mem_rdata[15:0]};
                    2'd2: load_val = {rt_old[31:24], mem_rdata[23:0]};
                    2'd3: load_val = mem_rdata;
                endcase
            end
            default: load_val = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns load data, registers write-back controls, counts retirements.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  word_t               mem_rdata,
    input  word_t               alu_result,
    input  word_t               rt_old,
    input  mem_op_t             mem_op,
    input  logic                mem_to_reg,
    input  logic                reg_write,
    input  logic [4:0]          write_reg,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic [4:0]          wb_reg,
    output word_t               wb_data,
    output logic [RETIRE_W-1:0] retired
);

    word_t load_val;
    word_t cap_data;
    logic  cap_we;

    load_align u_load_align (
        .mem_op    (mem_op),
        .k         (alu_result[1:0]),
        .mem_rdata (mem_rdata),
        .rt_old    (rt_old),
        .load_val  (load_val)
    );

    assign cap_data = mem_to_reg ? load_val : alu_result;
    // $0 is hardwired to zero, so never enable a write to it.
    assign cap_we   = reg_write & mem_valid & (write_reg != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= '0;
            retired      <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= '0;
        end else if (!stall) begin
            wb_valid     <= mem_valid;
            wb_reg_write <= cap_we;
            wb_reg       <= write_reg;
            wb_data      <= cap_data;
            retired      <= retired + RETIRE_W'(mem_valid);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for alignment/enables plus stall, flush, reset, wrap.
module tb_mem_wb_stage;
    import mips_pkg::*;

    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, flush, mem_valid, mem_to_reg, reg_write;
    word_t         mem_rdata, alu_result, rt_old;
    mem_op_t       mem_op;
    logic [4:0]    write_reg;
    logic          wb_valid, wb_reg_write;
    logic [4:0]    wb_reg;
    word_t         wb_data;
    logic [RW-1:0] retired;

    int n_pass = 0;
    int n_total = 0;
    logic [RW-1:0] exp_ret;

    always #5 clk = ~clk;

    mem_wb_stage #(.RETIRE_W(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .alu_result   (alu_result),
        .rt_old       (rt_old),
        .mem_op       (mem_op),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .retired      (retired)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        word_t      alu;
        word_t      rdata;
        word_t      rt;
        logic       m2r;
        logic       rw;
        logic [4:0] wreg;
        logic       valid;
        word_t      exp_data;
        logic       exp_we;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [3:0] op, input word_t alu, input word_t rd,
                       input word_t rt, input logic m2r, input logic rw, input logic [4:0] wr,
                       input logic v, input word_t ed, input logic ew);
        vec_t t;
        t.name = nm; t.op = op; t.alu = alu; t.rdata = rd; t.rt = rt; t.m2r = m2r; t.rw = rw;
        t.wreg = wr; t.valid = v; t.exp_data = ed; t.exp_we = ew;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic check_all(input string nm, input logic v, input logic we, input logic [4:0] r,
                             input word_t d, input logic [RW-1:0] ret);
        check({nm, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
        check({nm, ".we"}, {31'd0, wb_reg_write}, {31'd0, we});
        check({nm, ".reg"}, {27'd0, wb_reg}, {27'd0, r});
        check({nm, ".data"}, wb_data, d);
        check({nm, ".retired"}, {{(32-RW){1'b0}}, retired}, {{(32-RW){1'b0}}, ret});
    endtask

    task automatic drive(input vec_t t);
        mem_op = t.op; alu_result = t.alu; mem_rdata = t.rdata; rt_old = t.rt;
        mem_to_reg = t.m2r; reg_write = t.rw; write_reg = t.wreg; mem_valid = t.valid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        #2 rst = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        vec_t a;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0; alu_result = '0; rt_old = '0; mem_op = '0;
        mem_to_reg = 1'b0; reg_write = 1'b0; write_reg = '0;

        add("lwl_k1", MEMOP_LWL, 32'h11, 32'hAABBCCDD, 32'h11223344, 1, 1, 8, 1, 32'hAABBCC44, 1);
        add("lwr_k1", MEMOP_LWR, 32'h11, 32'hAABBCCDD, 32'h11223344, 1, 1, 9, 1, 32'h1122CCDD, 1);
        add("lwr_k3", MEMOP_LWR, 32'h13, 32'hAABBCCDD, 32'h11223344, 1, 1, 9, 1, 32'hAABBCCDD, 1);
        add("lwl_k0", MEMOP_LWL, 32'h100, 32'hAABBCCDD, 32'h11223344, 1, 1, 4, 1, 32'hAABBCCDD, 1);
        add("lwl_k2", MEMOP_LWL, 32'h102, 32'hAABBCCDD, 32'h11223344, 1, 1, 4, 1, 32'hAABB3344, 1);
        add("lwl_k3", MEMOP_LWL, 32'h103, 32'hAABBCCDD, 32'h11223344, 1, 1, 4, 1, 32'hAA223344, 1);
        add("lwr_k0", MEMOP_LWR, 32'h200, 32'hAABBCCDD, 32'h11223344, 1, 1, 5, 1, 32'h112233DD, 1);
        add("lwr_k2", MEMOP_LWR, 32'h202, 32'hAABBCCDD, 32'h11223344, 1, 1, 5, 1, 32'h11BBCCDD, 1);
        add("lb_pass", MEMOP_LB, 32'h203, 32'hFFFFFF80, 32'h11223344, 1, 1, 31, 1, 32'hFFFFFF80, 1);
        add("zero_dst", 4'b0000, 32'h5, 32'hDEADBEEF, 32'h0, 0, 1, 0, 1, 32'h5, 0);
        add("nonld_m2r", 4'b0000, 32'h7, 32'hCAFEF00D, 32'h0, 1, 1, 2, 1, 32'hCAFEF00D, 1);
        add("invalid", MEMOP_LW, 32'h44, 32'h12345678, 32'h0, 1, 1, 3, 0, 32'h12345678, 0);
        add("lhu_alu", MEMOP_LHU, 32'h9, 32'h0000BEEF, 32'h0, 0, 0, 6, 1, 32'h9, 0);

        // Outputs are zero while reset is held, even across clock edges.
        mem_valid = 1'b1; reg_write = 1'b1; write_reg = 5'd7; alu_result = 32'h55;
        #2 check_all("reset_hold", 0, 0, 0, 32'h0, 0);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            exp_ret = exp_ret + RW'(vecs[i].valid);
            check_all(vecs[i].name, vecs[i].valid, vecs[i].exp_we, vecs[i].wreg,
                      vecs[i].exp_data, exp_ret);
        end

        // Stall holds instruction A for three cycles despite changing inputs.
        a = vecs[0];
        drive(a);
        step();
        exp_ret = exp_ret + 1'b1;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(vecs[c + 1]);
            step();
            check_all($sformatf("stall%0d", c), 1, 1, 8, 32'hAABBCC44, exp_ret);
        end
        flush = 1'b1;
        step();
        check_all("stall_flush", 0, 0, 0, 32'h0, exp_ret);
        stall = 1'b0; flush = 1'b0;

        // Bring the counter to 7, then assert reset between edges.
        do_reset();
        drive(vecs[0]);
        for (int c = 0; c < 7; c++) step();
        check_all("pre_async", 1, 1, 8, 32'hAABBCC44, 7);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 32'h0, 0);
        step();
        check_all("rst_edge", 0, 0, 0, 32'h0, 0);
        #2 rst = 1'b0;
        step();
        check_all("post_rst", 1, 1, 8, 32'hAABBCC44, 1);

        // Counter wraps modulo 2^RW.
        do_reset();
        drive(vecs[9]);
        for (int c = 0; c < 16; c++) step();
        check_all("wrap16", 1, 0, 0, 32'h5, 0);
        step();
        check_all("wrap17", 1, 0, 0, 32'h5, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
